// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - shared types and opcode constants for the immediate generator
package imm_gen_pkg;

   localparam int IMM_MAX_W = 64;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd7
   } fmt_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;

   // imm is always built at full width; narrower configurations take the low bits
   typedef struct packed {
      logic [IMM_MAX_W-1:0] imm;
      fmt_t                 fmt;
      logic                 illegal;
   } entry_t;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational format decode and immediate extension
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0] instr_i,
   input  logic        zext_i,
   output entry_t      entry_o
);

   logic fill;

   always_comb begin
      fill            = ~zext_i & instr_i[31];
      entry_o         = '0;
      entry_o.fmt     = FMT_ILL;
      entry_o.illegal = 1'b1;

      // instr[1:0] != 11 can never match a listed opcode, so it falls to ILL
      case (instr_i[6:0])
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
            entry_o.fmt     = FMT_I;
            entry_o.illegal = 1'b0;
            entry_o.imm     = {{52{fill}}, instr_i[31:20]};
         end
         OP_IMM32: begin
            if (XLEN == 64) begin
               entry_o.fmt     = FMT_I;
               entry_o.illegal = 1'b0;
               entry_o.imm     = {{52{fill}}, instr_i[31:20]};
            end
         end
         OP_STORE: begin
            entry_o.fmt     = FMT_S;
            entry_o.illegal = 1'b0;
            entry_o.imm     = {{52{fill}}, instr_i[31:25], instr_i[11:7]};
         end
         OP_BRANCH: begin
            entry_o.fmt     = FMT_B;
            entry_o.illegal = 1'b0;
            entry_o.imm     = {{51{fill}}, instr_i[31], instr_i[7],
                               instr_i[30:25], instr_i[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            entry_o.fmt     = FMT_U;
            entry_o.illegal = 1'b0;
            entry_o.imm     = {{32{fill}}, instr_i[31:12], 12'b0};
         end
         OP_JAL: begin
            entry_o.fmt     = FMT_J;
            entry_o.illegal = 1'b0;
            entry_o.imm     = {{43{fill}}, instr_i[31], instr_i[19:12],
                               instr_i[20], instr_i[30:21], 1'b0};
         end
         OP_REG, OP_REG32: begin
            entry_o.fmt     = FMT_R;
            entry_o.illegal = 1'b0;
         end
         default: begin
            entry_o.fmt     = FMT_ILL;
            entry_o.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - immediate generator behind a 2-entry ready/valid buffer
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic             in_zext,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] ill_count
);

   entry_t           dec_entry;
   entry_t           mem_q [2];
   entry_t           head;
   logic [1:0]       count_q, count_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] ill_q, ill_d;
   logic             accept, pop;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .instr_i (in_instr),
      .zext_i  (in_zext),
      .entry_o (dec_entry)
   );

   // in_ready depends only on the registered count, never on out_ready
   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign head      = mem_q[rd_ptr_q];

   assign out_imm     = out_valid ? head.imm[XLEN-1:0] : '0;
   assign out_fmt     = out_valid ? head.fmt : FMT_R;
   assign out_illegal = out_valid & head.illegal;
   assign ill_count   = ill_q;

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ill_d    = ill_q;
      case ({accept, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      if (accept) wr_ptr_d = ~wr_ptr_q;
      if (pop)    rd_ptr_d = ~rd_ptr_q;
      if (clr_cnt) begin
         ill_d = '0;
      end else if (accept && dec_entry.illegal && (ill_q != '1)) begin
         ill_d = ill_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         ill_q    <= '0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ill_q    <= ill_d;
         if (accept) mem_q[wr_ptr_q] <= dec_entry;
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_instr;
   logic        in_zext;
   logic        out_ready;
   logic        clr_cnt;

   logic        a_in_ready, a_out_valid, a_out_illegal;
   logic [63:0] a_out_imm;
   logic [2:0]  a_out_fmt;
   logic [15:0] a_ill;

   logic        b_in_ready, b_out_valid, b_out_illegal;
   logic [31:0] b_out_imm;
   logic [2:0]  b_out_fmt;
   logic [15:0] b_ill;

   logic        c_in_ready, c_out_valid, c_out_illegal;
   logic [63:0] c_out_imm;
   logic [2:0]  c_out_fmt;
   logic [1:0]  c_ill;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(64), .CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_instr(in_instr), .in_zext(in_zext), .out_valid(a_out_valid),
      .out_ready(out_ready), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
      .out_illegal(a_out_illegal), .clr_cnt(clr_cnt), .ill_count(a_ill)
   );

   imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_instr(in_instr), .in_zext(in_zext), .out_valid(b_out_valid),
      .out_ready(out_ready), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
      .out_illegal(b_out_illegal), .clr_cnt(clr_cnt), .ill_count(b_ill)
   );

   imm_gen_pipe #(.XLEN(64), .CNT_W(2)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_instr(in_instr), .in_zext(in_zext), .out_valid(c_out_valid),
      .out_ready(out_ready), .out_imm(c_out_imm), .out_fmt(c_out_fmt),
      .out_illegal(c_out_illegal), .clr_cnt(clr_cnt), .ill_count(c_ill)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 32'h0;
      in_zext   = 1'b0;
      out_ready = 1'b0;
      clr_cnt   = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); else passed++;
      total++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); else passed++;
      total++; if (a_out_imm !== 64'h0) $display("FAIL reset_out_imm: got %h expected 0", a_out_imm); else passed++;
      total++; if (a_out_fmt !== 3'd0) $display("FAIL reset_out_fmt: got %0d expected 0", a_out_fmt); else passed++;
      total++; if (a_out_illegal !== 1'b0) $display("FAIL reset_out_illegal: got %b expected 0", a_out_illegal); else passed++;
      total++; if (a_ill !== 16'd0) $display("FAIL reset_ill_count: got %0d expected 0", a_ill); else passed++;
   endtask

   task automatic test_formats_stream();
      logic [31:0] vi [15];
      logic        vz [15];
      logic [63:0] ve [15];
      logic [2:0]  vf [15];
      logic        vl [15];
      vi[0]  = 32'hFFF00093; vz[0]  = 0; ve[0]  = 64'hFFFFFFFFFFFFFFFF; vf[0]  = 1; vl[0]  = 0;
      vi[1]  = 32'hFFF00093; vz[1]  = 1; ve[1]  = 64'h0000000000000FFF; vf[1]  = 1; vl[1]  = 0;
      vi[2]  = 32'hFE000EE3; vz[2]  = 0; ve[2]  = 64'hFFFFFFFFFFFFFFFC; vf[2]  = 3; vl[2]  = 0;
      vi[3]  = 32'h800002B7; vz[3]  = 0; ve[3]  = 64'hFFFFFFFF80000000; vf[3]  = 4; vl[3]  = 0;
      vi[4]  = 32'h800002B7; vz[4]  = 1; ve[4]  = 64'h0000000080000000; vf[4]  = 4; vl[4]  = 0;
      vi[5]  = 32'hFE112E23; vz[5]  = 0; ve[5]  = 64'hFFFFFFFFFFFFFFFC; vf[5]  = 2; vl[5]  = 0;
      vi[6]  = 32'h008000EF; vz[6]  = 0; ve[6]  = 64'h0000000000000008; vf[6]  = 5; vl[6]  = 0;
      vi[7]  = 32'hFFDFF06F; vz[7]  = 1; ve[7]  = 64'h00000000001FFFFC; vf[7]  = 5; vl[7]  = 0;
      vi[8]  = 32'h002081B3; vz[8]  = 1; ve[8]  = 64'h0;                vf[8]  = 0; vl[8]  = 0;
      vi[9]  = 32'h0000007F; vz[9]  = 0; ve[9]  = 64'h0;                vf[9]  = 7; vl[9]  = 1;
      vi[10] = 32'hFFF00090; vz[10] = 0; ve[10] = 64'h0;                vf[10] = 7; vl[10] = 1;
      vi[11] = 32'h0000001B; vz[11] = 0; ve[11] = 64'h0;                vf[11] = 1; vl[11] = 0;
      vi[12] = 32'hFFFFF097; vz[12] = 0; ve[12] = 64'hFFFFFFFFFFFFF000; vf[12] = 4; vl[12] = 0;
      vi[13] = 32'hFE000EE3; vz[13] = 1; ve[13] = 64'h0000000000001FFC; vf[13] = 3; vl[13] = 0;
      vi[14] = 32'h00000073; vz[14] = 0; ve[14] = 64'h0;                vf[14] = 1; vl[14] = 0;
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         in_valid = 1'b1;
         in_instr = vi[i];
         in_zext  = vz[i];
         step();
         total++; if (a_out_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b expected 1", i, a_out_valid); else passed++;
         total++; if (a_out_imm !== ve[i]) $display("FAIL stream_imm[%0d]: got %h expected %h", i, a_out_imm, ve[i]); else passed++;
         total++; if (a_out_fmt !== vf[i]) $display("FAIL stream_fmt[%0d]: got %0d expected %0d", i, a_out_fmt, vf[i]); else passed++;
         total++; if (a_out_illegal !== vl[i]) $display("FAIL stream_illegal[%0d]: got %b expected %b", i, a_out_illegal, vl[i]); else passed++;
      end
      in_valid = 1'b0;
      step();
      total++; if (a_out_valid !== 1'b0) $display("FAIL stream_drain: got %b expected 0", a_out_valid); else passed++;
      total++; if (a_ill !== 16'd2) $display("FAIL stream_ill_count: got %0d expected 2", a_ill); else passed++;
   endtask

   task automatic test_xlen32();
      apply_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 32'h0000001B;
      in_zext   = 1'b0;
      step();
      total++; if (b_out_illegal !== 1'b1) $display("FAIL x32_imm32_illegal: got %b expected 1", b_out_illegal); else passed++;
      total++; if (b_out_fmt !== 3'd7) $display("FAIL x32_imm32_fmt: got %0d expected 7", b_out_fmt); else passed++;
      total++; if (b_out_imm !== 32'h0) $display("FAIL x32_imm32_imm: got %h expected 0", b_out_imm); else passed++;
      total++; if (b_ill !== 16'd1) $display("FAIL x32_ill_count: got %0d expected 1", b_ill); else passed++;
      total++; if (a_out_fmt !== 3'd1) $display("FAIL x64_imm32_fmt: got %0d expected 1", a_out_fmt); else passed++;
      total++; if (a_out_illegal !== 1'b0) $display("FAIL x64_imm32_illegal: got %b expected 0", a_out_illegal); else passed++;
      in_instr = 32'hFFF00093;
      step();
      total++; if (b_out_imm !== 32'hFFFFFFFF) $display("FAIL x32_addi_imm: got %h expected ffffffff", b_out_imm); else passed++;
      in_instr = 32'h800002B7;
      in_zext  = 1'b1;
      step();
      total++; if (b_out_imm !== 32'h80000000) $display("FAIL x32_lui_imm: got %h expected 80000000", b_out_imm); else passed++;
      total++; if (b_out_fmt !== 3'd4) $display("FAIL x32_lui_fmt: got %0d expected 4", b_out_fmt); else passed++;
      in_instr = 32'hFFDFF06F;
      in_zext  = 1'b0;
      step();
      total++; if (b_out_imm !== 32'hFFFFFFFC) $display("FAIL x32_jal_imm: got %h expected fffffffc", b_out_imm); else passed++;
      in_valid = 1'b0;
      step();
      total++; if (b_ill !== 16'd1) $display("FAIL x32_ill_count_end: got %0d expected 1", b_ill); else passed++;
   endtask

   task automatic test_back_to_back();
      apply_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_zext   = 1'b0;
      in_instr  = 32'h00100093;
      step();
      total++; if (a_in_ready !== 1'b1) $display("FAIL bp_ready_after_1: got %b expected 1", a_in_ready); else passed++;
      in_instr = 32'h00200093;
      step();
      total++; if (a_in_ready !== 1'b0) $display("FAIL bp_ready_after_2: got %b expected 0", a_in_ready); else passed++;
      total++; if (a_out_imm !== 64'd1) $display("FAIL bp_head_a: got %h expected 1", a_out_imm); else passed++;
      in_instr = 32'h00300093;
      step();
      total++; if (a_in_ready !== 1'b0) $display("FAIL bp_ready_full: got %b expected 0", a_in_ready); else passed++;
      total++; if (a_out_imm !== 64'd1) $display("FAIL bp_head_stable: got %h expected 1", a_out_imm); else passed++;
      total++; if (a_out_valid !== 1'b1) $display("FAIL bp_valid_stable: got %b expected 1", a_out_valid); else passed++;
      out_ready = 1'b1;
      step();
      total++; if (a_out_imm !== 64'd2) $display("FAIL bp_head_b: got %h expected 2", a_out_imm); else passed++;
      total++; if (a_in_ready !== 1'b1) $display("FAIL bp_ready_after_pop: got %b expected 1", a_in_ready); else passed++;
      step();
      total++; if (a_out_imm !== 64'd3) $display("FAIL bp_head_c: got %h expected 3", a_out_imm); else passed++;
      total++; if (a_in_ready !== 1'b1) $display("FAIL bp_ready_steady: got %b expected 1", a_in_ready); else passed++;
      in_valid = 1'b0;
      step();
      total++; if (a_out_valid !== 1'b0) $display("FAIL bp_empty: got %b expected 0", a_out_valid); else passed++;
   endtask

   task automatic test_saturate();
      logic [1:0] exp;
      apply_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 32'h0000007F;
      for (int k = 1; k <= 5; k++) begin
         step();
         exp = (k < 3) ? 2'(k) : 2'd3;
         total++; if (c_ill !== exp) $display("FAIL sat_count[%0d]: got %0d expected %0d", k, c_ill, exp); else passed++;
      end
      clr_cnt = 1'b1;
      step();
      total++; if (c_ill !== 2'd0) $display("FAIL sat_clr_priority: got %0d expected 0", c_ill); else passed++;
      clr_cnt = 1'b0;
      step();
      total++; if (c_ill !== 2'd1) $display("FAIL sat_after_clr: got %0d expected 1", c_ill); else passed++;
      in_valid = 1'b0;
      step();
      total++; if (c_ill !== 2'd1) $display("FAIL sat_no_pop_count: got %0d expected 1", c_ill); else passed++;
   endtask

   task automatic test_async_reset();
      apply_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h0000007F;
      step();
      step();
      in_valid = 1'b0;
      total++; if (a_in_ready !== 1'b0) $display("FAIL ar_full_ready: got %b expected 0", a_in_ready); else passed++;
      total++; if (a_ill !== 16'd2) $display("FAIL ar_full_ill: got %0d expected 2", a_ill); else passed++;
      #2 rst_n = 1'b0;
      #1;
      total++; if (a_out_valid !== 1'b0) $display("FAIL ar_out_valid: got %b expected 0", a_out_valid); else passed++;
      total++; if (a_in_ready !== 1'b1) $display("FAIL ar_in_ready: got %b expected 1", a_in_ready); else passed++;
      total++; if (a_ill !== 16'd0) $display("FAIL ar_ill_count: got %0d expected 0", a_ill); else passed++;
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 32'h00100093;
      step();
      total++; if (a_out_valid !== 1'b1) $display("FAIL ar_first_valid: got %b expected 1", a_out_valid); else passed++;
      total++; if (a_out_imm !== 64'd1) $display("FAIL ar_first_imm: got %h expected 1", a_out_imm); else passed++;
      in_valid = 1'b0;
      step();
      total++; if (a_out_valid !== 1'b0) $display("FAIL ar_drain: got %b expected 0", a_out_valid); else passed++;
   endtask

   initial begin
      test_reset();
      test_formats_stream();
      test_xlen32();
      test_back_to_back();
      test_saturate();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the RISC-V decode stage.
- Extracts the immediate from all base formats (I, S, B, U, J, R) and extends it to XLEN. Extension is sign or zero, selected per request.
- Flags illegal opcodes and counts them.
- Sits between fetch/decode and register read, behind a 2-entry ready/valid buffer.

Parameters:
- XLEN, 64, output immediate width; legal values 32 or 64.
- CNT_W, 16, width of the saturating illegal-opcode counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction offered.
- in_ready  output  1  block can accept an instruction this cycle.
- in_instr  input  32  raw instruction word.
- in_zext  input  1  1 = zero-extend the immediate; 0 = sign-extend from instr[31].
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes the head entry.
- out_imm  output  XLEN  extended immediate.
- out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
- out_illegal  output  1  opcode not recognised.
- clr_cnt  input  1  synchronous clear of ill_count.
- ill_count  output  CNT_W  number of accepted illegal instructions, saturating.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Reset values: buffer empty, out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_illegal=0, ill_count=0.
- Reset mid-operation: asserting rst_n=0 discards all buffered entries immediately.
- Handshakes:
  - Accept occurs when in_valid & in_ready at a rising edge.
  - Pop occurs when out_valid & out_ready at a rising edge.
- Storage:
  - Decode is combinational at the input; the decoded result is stored in a 2-entry FIFO.
  - Outputs are driven from the head entry.
- Latency: an instruction accepted at edge N is presented with out_valid=1 after edge N. Throughput is 1 per cycle with out_ready held high.
- in_ready = (count != 2), derived only from registered count. There is no combinational path from out_ready to in_ready.
- Simultaneous accept and pop with count=1 leaves count at 1. With count=2, no accept is possible that cycle, even if a pop occurs.
- Order is strictly FIFO. out_* hold stable while out_valid=1 and out_ready=0.
- Format selection from opcode instr[6:0]:
  - 0000011, 0010011, 1100111, 1110011 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - 0110011, 0111011 -> R.
  - 0011011 -> I, only when XLEN=64; illegal when XLEN=32.
  - Any other opcode, including instr[1:0] != 11 -> ILL.
- Raw immediate fields:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - R and ILL: immediate is 0. in_zext is ignored for these.
- Extension:
  - Bits above the raw field width are filled with instr[31] when in_zext=0, and with 0 when in_zext=1.
  - U at XLEN=64 extends from bit 31.
  - Shift-immediate encodings receive no special treatment; they use the raw I field.
- ill_count:
  - Increments on acceptance of an ILL instruction, not on pop.
  - Saturates at 2^CNT_W-1.
  - clr_cnt has priority over a same-cycle increment; the result is 0.

Decomposition:
- Package imm_gen_pkg holds:
  - the fmt_t enum (R, I, S, B, U, J, ILL);
  - opcode constants (OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG, OP_REG32);
  - a packed struct for a FIFO entry: imm, fmt, illegal.
- Sub-module imm_decode (combinational, parametrised by XLEN) maps {instr, zext} to the entry struct. imm_gen_pipe wraps it with the FIFO and the counter.

Test Plan:
- XLEN=64, in_instr=0xFFF00093 (addi x1,x0,-1), in_zext=0 -> one cycle later out_imm=0xFFFFFFFFFFFFFFFF, out_fmt=1. Same instruction with in_zext=1 -> out_imm=0x0000000000000FFF.
- in_instr=0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFFFFFFFFFC, out_fmt=3. in_instr=0x800002B7 (lui x5,0x80000) -> 0xFFFFFFFF80000000 sign-extended, 0x0000000080000000 zero-extended.
- XLEN=32, in_instr=0x0000001B (OP_IMM32) -> out_illegal=1, out_fmt=7, out_imm=0, ill_count=1. The same word at XLEN=64 -> out_fmt=1, out_illegal=0.
- Backpressure: out_ready=0, offer 3 instructions back-to-back -> 2 accepted and in_ready=0 from the cycle after the 2nd accept. Raise out_ready -> entries emerge in order, 1 per cycle, and the 3rd is accepted once count<2.
- CNT_W=2, accept 5 illegal words (0x0000007F) -> ill_count=3, saturated. Assert clr_cnt in the same cycle as a 6th illegal accept -> ill_count=0.
- Fill the buffer to 2 entries, then pulse rst_n low asynchronously mid-cycle -> out_valid=0 and ill_count=0 immediately, and in_ready=1. The first instruction after release appears with 1-cycle latency.
